// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one external ALU between two requesters. Round-robin grant in IDLE,
// operands are registered on accept and held on the ALU ports for the whole
// EXEC phase, and the result is captured into a response register that is
// presented in RESP until the consumer takes it.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   req{0,1}_valid/_ready       requester handshake (ready is combinational)
//   req{0,1}_in1/_in2/_ctrl     requester operands and function code
//   alu_in1/_in2/_ctrl          operands/function driven to the shared ALU
//   alu_result, alu_zero        ALU outputs
//   resp_valid/_ready           response handshake
//   resp_id/_result/_zero/_illegal  captured response fields
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_in1,
  input  logic [31:0] req0_in2,
  input  logic [3:0]  req0_ctrl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_in1,
  input  logic [31:0] req1_in2,
  input  logic [3:0]  req1_ctrl,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_zero,
  output logic        resp_illegal
);

  localparam logic [3:0] CTRL_MUL = 4'b0110;
  localparam logic [3:0] MUL_CNT  = 4'(MUL_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Function codes 1010..1111 have no ALU operation behind them.
  function automatic logic is_illegal(input logic [3:0] code);
    return (code >= 4'b1010);
  endfunction

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] in1_q, in1_d;
  logic [31:0] in2_q, in2_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic        id_q, id_d;
  logic        resp_id_q, resp_id_d;
  logic [31:0] resp_result_q, resp_result_d;
  logic        resp_zero_q, resp_zero_d;
  logic        resp_illegal_q, resp_illegal_d;

  logic        grant_s;
  logic        accept_s;
  logic [3:0]  sel_ctrl_s;

  // Round-robin pick: on contention the requester that did not win last time.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_q;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Ready is only offered in IDLE, to the granted requester, and never in reset.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst && (state_q == IDLE)) begin
      req0_ready = req0_valid && !grant_s;
      req1_ready = req1_valid && grant_s;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  assign accept_s   = req0_ready | req1_ready;
  assign sel_ctrl_s = grant_s ? req1_ctrl : req0_ctrl;

  // Next-state and datapath update for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    cnt_d          = cnt_q;
    in1_d          = in1_q;
    in2_d          = in2_q;
    ctrl_d         = ctrl_q;
    id_d           = id_q;
    resp_id_d      = resp_id_q;
    resp_result_d  = resp_result_q;
    resp_zero_d    = resp_zero_q;
    resp_illegal_d = resp_illegal_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          in1_d        = grant_s ? req1_in1 : req0_in1;
          in2_d        = grant_s ? req1_in2 : req0_in2;
          ctrl_d       = sel_ctrl_s;
          id_d         = grant_s;
          last_grant_d = grant_s;
          cnt_d        = (sel_ctrl_s == CTRL_MUL) ? MUL_CNT : 4'd1;
          state_d      = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd1) begin
          // Last EXEC cycle: the ALU has seen stable operands long enough.
          resp_id_d = id_q;
          if (is_illegal(ctrl_q)) begin
            resp_result_d  = 32'd0;
            resp_zero_d    = 1'b1;
            resp_illegal_d = 1'b1;
          end else begin
            resp_result_d  = alu_result;
            resp_zero_d    = alu_zero;
            resp_illegal_d = 1'b0;
          end
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = EXEC;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; last_grant resets to 1 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      cnt_q          <= 4'd0;
      in1_q          <= 32'd0;
      in2_q          <= 32'd0;
      ctrl_q         <= 4'd0;
      id_q           <= 1'b0;
      resp_id_q      <= 1'b0;
      resp_result_q  <= 32'd0;
      resp_zero_q    <= 1'b0;
      resp_illegal_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      cnt_q          <= cnt_d;
      in1_q          <= in1_d;
      in2_q          <= in2_d;
      ctrl_q         <= ctrl_d;
      id_q           <= id_d;
      resp_id_q      <= resp_id_d;
      resp_result_q  <= resp_result_d;
      resp_zero_q    <= resp_zero_d;
      resp_illegal_q <= resp_illegal_d;
    end
  end

  assign alu_in1      = in1_q;
  assign alu_in2      = in2_q;
  assign alu_ctrl     = ctrl_q;
  assign resp_valid   = (state_q == RESP);
  assign resp_id      = resp_id_q;
  assign resp_result  = resp_result_q;
  assign resp_zero    = resp_zero_q;
  assign resp_illegal = resp_illegal_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int MUL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_in1 = 32'd0, req0_in2 = 32'd0, req1_in1 = 32'd0, req1_in2 = 32'd0;
  logic [3:0]  req0_ctrl = 4'd0, req1_ctrl = 4'd0;
  logic [31:0] alu_in1, alu_in2, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;
  logic        resp_valid, resp_ready = 1'b1, resp_id, resp_zero, resp_illegal;
  logic [31:0] resp_result;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic last_gnt = 1'b1;  // model of the round-robin history

  alu_arbiter #(.MUL_CYCLES(MUL)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_ctrl(req1_ctrl),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_illegal(resp_illegal)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; illegal codes return a nonzero marker so misuse is visible.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a * b;
      4'b0111: return (a < b) ? 32'd1 : 32'd0;
      4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111: return 32'hBAD0_BAD0;
      default: return a - b;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_in1, alu_in2, alu_ctrl);
  assign alu_zero   = (alu_result == 32'd0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    tick(); #1;
    total_cnt++; if (req0_ready !== 1'b0) $display("FAIL reset_ready0 got=%0b exp=0", req0_ready); else pass_cnt++;
    total_cnt++; if (req1_ready !== 1'b0) $display("FAIL reset_ready1 got=%0b exp=0", req1_ready); else pass_cnt++;
    total_cnt++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got=%0b exp=0", resp_valid); else pass_cnt++;
    total_cnt++; if ({alu_in1, alu_in2, alu_ctrl} !== 68'd0) $display("FAIL reset_alu_ops got=%h exp=0", {alu_in1, alu_in2, alu_ctrl}); else pass_cnt++;
    total_cnt++; if ({resp_id, resp_result, resp_zero, resp_illegal} !== 35'd0) $display("FAIL reset_resp got=%h exp=0", {resp_id, resp_result, resp_zero, resp_illegal}); else pass_cnt++;
    tick();
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    last_gnt = 1'b1;
    tick();
  endtask

  task automatic test_add();
    req0_valid = 1'b1; req0_in1 = 32'd5; req0_in2 = 32'd7; req0_ctrl = 4'b0010;
    #1;
    total_cnt++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL add_ready got=%b exp=10", {req0_ready, req1_ready}); else pass_cnt++;
    tick();  // edge N: accept
    req0_valid = 1'b0; req0_in1 = 32'd99;
    total_cnt++; if (resp_valid !== 1'b0) $display("FAIL add_early_valid got=%0b exp=0", resp_valid); else pass_cnt++;
    total_cnt++; if ({alu_in1, alu_in2, alu_ctrl} !== {32'd5, 32'd7, 4'b0010}) $display("FAIL add_alu_ops got=%h", {alu_in1, alu_in2, alu_ctrl}); else pass_cnt++;
    tick();  // edge N+1
    total_cnt++; if (resp_valid !== 1'b1) $display("FAIL add_resp_valid got=%0b exp=1", resp_valid); else pass_cnt++;
    total_cnt++; if ({resp_id, resp_result, resp_zero, resp_illegal} !== {1'b0, 32'd12, 1'b0, 1'b0}) $display("FAIL add_resp got id=%0b res=%0d z=%0b ill=%0b exp 0/12/0/0", resp_id, resp_result, resp_zero, resp_illegal); else pass_cnt++;
    tick();
    last_gnt = 1'b0;
    total_cnt++; if (resp_valid !== 1'b0 || resp_result !== 32'd12) $display("FAIL add_after_resp got v=%0b res=%0d exp 0/12", resp_valid, resp_result); else pass_cnt++;
  endtask

  task automatic test_multiply();
    req1_valid = 1'b1; req1_in1 = 32'd3; req1_in2 = 32'd4; req1_ctrl = 4'b0110;
    #1;
    total_cnt++; if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL mul_ready got=%b exp=01", {req0_ready, req1_ready}); else pass_cnt++;
    tick();
    req1_valid = 1'b0; req1_in1 = 32'd0;
    for (int c = 1; c <= MUL; c++) begin
      total_cnt++; if ({alu_in1, alu_in2, alu_ctrl} !== {32'd3, 32'd4, 4'b0110}) $display("FAIL mul_alu_stable cyc=%0d got=%h", c, {alu_in1, alu_in2, alu_ctrl}); else pass_cnt++;
      total_cnt++; if (resp_valid !== 1'b0) $display("FAIL mul_early_valid cyc=%0d got=%0b exp=0", c, resp_valid); else pass_cnt++;
      tick();
    end
    total_cnt++; if ({resp_valid, resp_id, resp_result, resp_illegal} !== {1'b1, 1'b1, 32'd12, 1'b0}) $display("FAIL mul_resp got v=%0b id=%0b res=%0d ill=%0b exp 1/1/12/0", resp_valid, resp_id, resp_result, resp_illegal); else pass_cnt++;
    tick();
    last_gnt = 1'b1;
  endtask

  task automatic test_illegal();
    req0_valid = 1'b1; req0_in1 = 32'd9; req0_in2 = 32'd9; req0_ctrl = 4'b1100;
    tick();
    req0_valid = 1'b0;
    tick();
    total_cnt++; if ({resp_valid, resp_id, resp_result, resp_zero, resp_illegal} !== {1'b1, 1'b0, 32'd0, 1'b1, 1'b1}) $display("FAIL illegal_resp got v=%0b id=%0b res=%h z=%0b ill=%0b exp 1/0/0/1/1", resp_valid, resp_id, resp_result, resp_zero, resp_illegal); else pass_cnt++;
    tick();
    last_gnt = 1'b0;
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_in1 = 32'd1; req0_in2 = 32'd2; req0_ctrl = 4'b0010;
    tick();  // accept
    req0_in1 = 32'd100; req0_in2 = 32'd200;
    tick();  // now in RESP
    for (int i = 0; i < 5; i++) begin
      #1;
      total_cnt++; if ({resp_valid, resp_id, resp_result, resp_zero, resp_illegal} !== {1'b1, 1'b0, 32'd3, 1'b0, 1'b0}) $display("FAIL bp_hold cyc=%0d got v=%0b res=%0d", i, resp_valid, resp_result); else pass_cnt++;
      total_cnt++; if (req0_ready !== 1'b0) $display("FAIL bp_ready_in_resp cyc=%0d got=%0b exp=0", i, req0_ready); else pass_cnt++;
      tick();
    end
    resp_ready = 1'b1;
    #1;
    total_cnt++; if (req0_ready !== 1'b0) $display("FAIL bp_ready_same_cycle got=%0b exp=0", req0_ready); else pass_cnt++;
    tick();
    total_cnt++; if (req0_ready !== 1'b1) $display("FAIL bp_ready_after got=%0b exp=1", req0_ready); else pass_cnt++;
    tick();  // accept held request
    req0_valid = 1'b0;
    last_gnt = 1'b0;
    tick();
    total_cnt++; if ({resp_valid, resp_result} !== {1'b1, 32'd300}) $display("FAIL bp_second got v=%0b res=%0d exp 1/300", resp_valid, resp_result); else pass_cnt++;
    tick();
  endtask

  task automatic test_contention();
    int grants[$];
    int ids[$];
    int ready_pulses = 0;
    int cyc = 0;
    rst = 1'b1; tick(); rst = 1'b0; last_gnt = 1'b1;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_in1 = 32'd10; req0_in2 = 32'd1; req0_ctrl = 4'b0010;
    req1_valid = 1'b1; req1_in1 = 32'd20; req1_in2 = 32'd2; req1_ctrl = 4'b0010;
    while (ids.size() < 4 && cyc < 60) begin
      #1;
      if (req0_ready && req1_ready) begin
        total_cnt++; $display("FAIL cont_both_ready cyc=%0d got=11 exp=one-hot", cyc);
      end
      if (req0_ready || req1_ready) begin
        ready_pulses++;
        grants.push_back(req1_ready ? 1 : 0);
      end
      if (resp_valid) ids.push_back(int'(resp_id));
      if (ids.size() == 4) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    total_cnt++; if (ids.size() != 4) $display("FAIL cont_timeout got=%0d responses exp=4", ids.size()); else pass_cnt++;
    total_cnt++; if (ready_pulses != 4) $display("FAIL cont_ready_pulses got=%0d exp=4", ready_pulses); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      last_gnt = ~last_gnt;
      total_cnt++; if (k >= grants.size() || grants[k] != int'(last_gnt)) $display("FAIL cont_grant k=%0d got=%0d exp=%0d", k, (k < grants.size()) ? grants[k] : -1, last_gnt); else pass_cnt++;
      total_cnt++; if (k >= ids.size() || ids[k] != int'(last_gnt)) $display("FAIL cont_resp_id k=%0d got=%0d exp=%0d", k, (k < ids.size()) ? ids[k] : -1, last_gnt); else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_reset_mid_exec();
    req1_valid = 1'b1; req1_in1 = 32'd6; req1_in2 = 32'd7; req1_ctrl = 4'b0110;
    req0_valid = 1'b0;
    #1;
    total_cnt++; if (req1_ready !== 1'b1) $display("FAIL rme_ready1 got=%0b exp=1", req1_ready); else pass_cnt++;
    tick();  // in EXEC
    rst = 1'b1;
    #1;
    total_cnt++; if ({resp_valid, alu_in1, alu_in2, alu_ctrl} !== 69'd0) $display("FAIL rme_outputs got=%h exp=0", {resp_valid, alu_in1, alu_in2, alu_ctrl}); else pass_cnt++;
    total_cnt++; if ({resp_result, resp_id} !== 33'd0) $display("FAIL rme_resp_clear got=%h exp=0", {resp_result, resp_id}); else pass_cnt++;
    total_cnt++; if (req1_ready !== 1'b0) $display("FAIL rme_ready_in_rst got=%0b exp=0", req1_ready); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (resp_valid !== 1'b0) $display("FAIL rme_no_resp got=%0b exp=0", resp_valid); else pass_cnt++;
    rst = 1'b0; last_gnt = 1'b1;
    req0_valid = 1'b1; req0_in1 = 32'd10; req0_in2 = 32'd20; req0_ctrl = 4'b0010;
    #1;
    total_cnt++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rme_first_grant got=%b exp=10", {req0_ready, req1_ready}); else pass_cnt++;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0; last_gnt = 1'b0;
    tick();
    total_cnt++; if ({resp_valid, resp_id, resp_result} !== {1'b1, 1'b0, 32'd30}) $display("FAIL rme_after got v=%0b id=%0b res=%0d exp 1/0/30", resp_valid, resp_id, resp_result); else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    logic [3:0]  codes [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1010, 4'b1111};
    logic        v0, v1, g, exp_zero, exp_ill;
    logic [31:0] a, b, exp_res;
    logic [3:0]  c;
    int          lat, exp_lat, hold;
    for (int t = 0; t < 25; t++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      req0_in1 = $urandom; req0_in2 = $urandom; req0_ctrl = codes[$urandom_range(0, 7)];
      req1_in1 = $urandom; req1_in2 = $urandom; req1_ctrl = codes[$urandom_range(0, 7)];
      if (t % 4 == 0) req0_in2 = req0_in1;  // drives some zero results
      req0_valid = v0; req1_valid = v1; resp_ready = 1'b0;
      g = (v0 && v1) ? ~last_gnt : v1;
      a = g ? req1_in1 : req0_in1;
      b = g ? req1_in2 : req0_in2;
      c = g ? req1_ctrl : req0_ctrl;
      exp_ill = (c >= 4'b1010);
      exp_res = exp_ill ? 32'd0 : alu_fn(a, b, c);
      exp_zero = (exp_res == 32'd0);
      exp_lat = (c == 4'b0110) ? MUL : 1;
      #1;
      total_cnt++; if ({req0_ready, req1_ready} !== {~g, g}) $display("FAIL rnd_grant t=%0d got=%b exp=%b", t, {req0_ready, req1_ready}, {~g, g}); else pass_cnt++;
      tick();
      last_gnt = g;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_in1 = $urandom; req1_in1 = $urandom;
      total_cnt++; if ({alu_in1, alu_in2, alu_ctrl} !== {a, b, c}) $display("FAIL rnd_alu_ops t=%0d got=%h exp=%h", t, {alu_in1, alu_in2, alu_ctrl}, {a, b, c}); else pass_cnt++;
      lat = 0;
      while (!resp_valid && lat < 20) begin
        tick();
        lat++;
      end
      total_cnt++; if (lat != exp_lat) $display("FAIL rnd_latency t=%0d got=%0d exp=%0d", t, lat, exp_lat); else pass_cnt++;
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        tick();
        total_cnt++; if ({resp_valid, resp_result} !== {1'b1, exp_res}) $display("FAIL rnd_hold t=%0d got v=%0b res=%h exp 1/%h", t, resp_valid, resp_result, exp_res); else pass_cnt++;
      end
      resp_ready = 1'b1;
      #1;
      total_cnt++; if ({resp_id, resp_result, resp_zero, resp_illegal} !== {g, exp_res, exp_zero, exp_ill}) $display("FAIL rnd_resp t=%0d got id=%0b res=%h z=%0b ill=%0b exp %0b/%h/%0b/%0b", t, resp_id, resp_result, resp_zero, resp_illegal, g, exp_res, exp_zero, exp_ill); else pass_cnt++;
      tick();
      total_cnt++; if (resp_valid !== 1'b0) $display("FAIL rnd_resp_drop t=%0d got=%0b exp=0", t, resp_valid); else pass_cnt++;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_add();
    test_multiply();
    test_illegal();
    test_backpressure();
    test_contention();
    test_reset_mid_exec();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
